// File: rtl/c5efa7_fpga_bup_qsys_cpu_oci_dct_monitor_if.sv
// Capture/pop handshake bundle for the OCI DCT monitor.
// master drives capture words and pop requests; slave is the monitor.
interface c5efa7_fpga_bup_qsys_cpu_oci_dct_monitor_if #(
    parameter int DCT_W = 30,
    parameter int CNT_W = 4
) ();
    logic [DCT_W-1:0]       dct_buffer;
    logic [CNT_W-1:0]       dct_count;
    logic                   dct_valid;
    logic                   rd_en;
    logic [CNT_W+DCT_W-1:0] rd_data;
    logic                   rd_valid;

    modport master (
        output dct_buffer, dct_count, dct_valid, rd_en,
        input  rd_data, rd_valid
    );

    modport slave (
        input  dct_buffer, dct_count, dct_valid, rd_en,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/c5efa7_fpga_bup_qsys_cpu_oci_dct_monitor.sv
// OCI DCT capture monitor: FIFO of {count, buffer} words with an IDLE/CAPTURE/DRAIN/DONE lifecycle.
// Optional macro OCI_DCT_COUNT_CHECK_EN enables the sticky dct_count range check (count_err).
module c5efa7_fpga_bup_qsys_cpu_oci_dct_monitor #(
    parameter int DCT_W     = 30,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 16,
    parameter int MAX_COUNT = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    c5efa7_fpga_bup_qsys_cpu_oci_dct_monitor_if.slave bus,
    input  logic                    test_ending,
    input  logic                    test_has_ended,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             accepted,
    output logic [15:0]             dropped,
    output logic                    overflow,
    output logic [1:0]              state,
    output logic                    done,
    output logic                    count_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = CNT_W + DCT_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        MAX_COUNT < 1 || MAX_COUNT >= (1 << CNT_W)) begin : g_param_chk
        $error("c5efa7 dct monitor: illegal DEPTH/MAX_COUNT/CNT_W");
    end

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   accepted_q, accepted_d, dropped_q, dropped_d;
    logic          overflow_q, overflow_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic capturing, wr_req, full, pop, wr, drop;

    // test_ending wins over dct_valid: the word is neither stored nor counted as dropped
    assign capturing = (state_q == S_IDLE) || (state_q == S_CAPTURE);
    assign wr_req    = capturing && !test_ending && bus.dct_valid;
    assign full      = (level_q == LW'(DEPTH));
    assign pop       = bus.rd_en && (level_q != '0);
    assign wr        = wr_req && (!full || pop);
    assign drop      = wr_req && full && !pop;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wr  ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        level_d    = level_q + LW'(wr) - LW'(pop);
        accepted_d = (wr && accepted_q != 16'hFFFF) ? accepted_q + 16'd1 : accepted_q;
        dropped_d  = (drop && dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;
        overflow_d = overflow_q || drop;
        rd_valid_d = pop;
        rd_data_d  = pop ? mem_q[rptr_q] : rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (test_ending)        state_d = S_DRAIN;
                else if (bus.dct_valid) state_d = S_CAPTURE;
            end
            S_CAPTURE: if (test_ending) state_d = S_DRAIN;
            S_DRAIN:   if (test_has_ended && level_q == '0) state_d = S_DONE;
            default:   state_d = S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            accepted_q <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            accepted_q <= accepted_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && wr) mem_q[wptr_q] <= {bus.dct_count, bus.dct_buffer};
    end

`ifdef OCI_DCT_COUNT_CHECK_EN
    logic count_err_q;
    always_ff @(posedge clk) begin
        if (reset)
            count_err_q <= 1'b0;
        else if (wr_req && (bus.dct_count == '0 || int'(bus.dct_count) > MAX_COUNT))
            count_err_q <= 1'b1;
    end
    assign count_err = count_err_q;
`else
    assign count_err = 1'b0;
`endif

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign level        = level_q;
    assign accepted     = accepted_q;
    assign dropped      = dropped_q;
    assign overflow     = overflow_q;
    assign state        = state_q;
    assign done         = (state_q == S_DONE);
endmodule
